// File: rtl/wallace_dot_pkg.sv
// Shared types and widths for the Wallace-tree dot-product sequencer.
package wallace_dot_pkg;

  localparam int unsigned OP_W  = 32;
  localparam int unsigned ACC_W = 64;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDrain,
    StDone
  } state_e;

endpackage

// File: rtl/wallaceTreeMultiplier32Bit.sv
// Combinational 32x32 unsigned multiplier: partial products reduced by 3:2 carry-save
// layers (32->22->15->10->7->5->4->3->2 rows) followed by one carry-propagate add.
module wallaceTreeMultiplier32Bit
  import wallace_dot_pkg::*;
(
  input  logic [OP_W-1:0]  a_i,
  input  logic [OP_W-1:0]  b_i,
  output logic [ACC_W-1:0] prod_o
);

  always_comb begin
    logic [ACC_W-1:0] pp  [32];
    logic [ACC_W-1:0] nxt [32];
    logic [ACC_W-1:0] x, y, z;
    int n, m;
    for (int i = 0; i < 32; i++) begin
      pp[i] = b_i[i] ? (ACC_W'(a_i) << i) : '0;
    end
    n = 32;
    for (int s = 0; s < 8; s++) begin
      m   = 0;
      nxt = pp;
      for (int g = 0; g < 10; g++) begin
        if (3 * g + 2 < n) begin
          x = pp[5'(3 * g)];
          y = pp[5'(3 * g + 1)];
          z = pp[5'(3 * g + 2)];
          nxt[5'(m)]     = x ^ y ^ z;
          // Carries beyond bit 63 are dropped; the full product always fits in 64 bits.
          nxt[5'(m + 1)] = ((x & y) | (x & z) | (y & z)) << 1;
          m = m + 2;
        end
      end
      for (int r = 0; r < 32; r++) begin
        if (r >= 3 * (n / 3) && r < n) begin
          nxt[5'(m)] = pp[5'(r)];
          m = m + 1;
        end
      end
      pp = nxt;
      n  = m;
    end
    prod_o = pp[0] + pp[1];
  end

endmodule

// File: rtl/wallace_dot_seq.sv
// Dot-product sequencer: streams operand pairs through one shared Wallace multiplier,
// accumulates the 64-bit products and returns the sum on a valid/ready result port.
module wallace_dot_seq
  import wallace_dot_pkg::*;
#(
  parameter int unsigned LEN_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [LEN_W-1:0] start_len,
  input  logic             op_valid,
  output logic             op_ready,
  input  logic [OP_W-1:0]  op_a,
  input  logic [OP_W-1:0]  op_b,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [ACC_W-1:0] res_data,
  output logic             res_ovf,
  output logic             busy
);

  state_e           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [ACC_W-1:0] prod_q, prod_d;
  logic             prod_v_q, prod_v_d;
  logic             ovf_q, ovf_d;
  logic [LEN_W-1:0] remaining_q, remaining_d;
  logic [ACC_W-1:0] mult;
  logic [ACC_W:0]   sum;
  logic             start_hs, op_hs, res_hs;

  wallaceTreeMultiplier32Bit u_mult (
    .a_i   (op_a),
    .b_i   (op_b),
    .prod_o(mult)
  );

  assign start_hs = start_valid & start_ready;
  assign op_hs    = op_valid & op_ready;
  assign res_hs   = res_valid & res_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start_hs) state_d = (start_len == '0) ? StDone : StRun;
      StRun:   if (op_hs && remaining_q == LEN_W'(1)) state_d = StDrain;
      StDrain: state_d = StDone;
      StDone:  if (res_hs) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    start_ready = (state_q == StIdle);
    op_ready    = (state_q == StRun);
    res_valid   = (state_q == StDone);
    busy        = (state_q != StIdle);
  end

  // Product add and start-clear never coincide: prod_v is always low in IDLE.
  always_comb begin
    sum         = {1'b0, acc_q} + {1'b0, prod_q};
    acc_d       = acc_q;
    ovf_d       = ovf_q;
    prod_d      = prod_q;
    prod_v_d    = op_hs;
    remaining_d = remaining_q;
    if (prod_v_q) begin
      acc_d = sum[ACC_W-1:0];
      ovf_d = ovf_q | sum[ACC_W];
    end
    if (start_hs) begin
      acc_d       = '0;
      ovf_d       = 1'b0;
      remaining_d = start_len;
    end
    if (op_hs) begin
      prod_d      = mult;
      remaining_d = remaining_q - LEN_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q       <= '0;
      ovf_q       <= 1'b0;
      prod_q      <= '0;
      prod_v_q    <= 1'b0;
      remaining_q <= '0;
    end else begin
      acc_q       <= acc_d;
      ovf_q       <= ovf_d;
      prod_q      <= prod_d;
      prod_v_q    <= prod_v_d;
      remaining_q <= remaining_d;
    end
  end

  assign res_data = acc_q;
  assign res_ovf  = ovf_q;

endmodule

// File: tb/tb_wallace_dot_seq.sv
// Directed and random jobs against wallace_dot_seq with hand-computed and modelled sums.
module tb_wallace_dot_seq;

  localparam int LEN_W = 8;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start_valid, start_ready;
  logic [LEN_W-1:0] start_len;
  logic             op_valid, op_ready;
  logic [31:0]      op_a, op_b;
  logic             res_valid, res_ready;
  logic [63:0]      res_data;
  logic             res_ovf, busy;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] va [256];
  logic [31:0] vb [256];

  wallace_dot_seq #(.LEN_W(LEN_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start_valid(start_valid),
    .start_ready(start_ready),
    .start_len  (start_len),
    .op_valid   (op_valid),
    .op_ready   (op_ready),
    .op_a       (op_a),
    .op_b       (op_b),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_data   (res_data),
    .res_ovf    (res_ovf),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_job(input string tag, input int len, input int max_gap, input int res_stall,
                         input bit poke_start, input logic [63:0] exp_data, input bit exp_ovf);
    int wait_n;
    int g;
    start_valid = 1'b1;
    start_len   = 8'(len);
    wait_n = 0;
    while (!start_ready && wait_n < 50) begin
      step();
      wait_n++;
    end
    check({tag, "/start_rdy"}, 64'(start_ready), 64'd1);
    step();
    start_valid = 1'b0;
    for (int i = 0; i < len; i++) begin
      g = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
      op_valid = 1'b0;
      for (int k = 0; k < g; k++) begin
        if (poke_start) begin
          start_valid = 1'b1;
          start_len   = 8'd7;
          check({tag, "/run_start_rdy"}, 64'(start_ready), 64'd0);
        end
        step();
        start_valid = 1'b0;
      end
      op_valid = 1'b1;
      op_a     = va[i];
      op_b     = vb[i];
      wait_n = 0;
      while (!op_ready && wait_n < 50) begin
        step();
        wait_n++;
      end
      check({tag, "/op_rdy"}, 64'(op_ready), 64'd1);
      step();
    end
    op_valid = 1'b0;
    wait_n = 0;
    while (!res_valid && wait_n < 300) begin
      step();
      wait_n++;
    end
    check({tag, "/lat"}, 64'(wait_n), (len == 0) ? 64'd0 : 64'd1);
    for (int k = 0; k < res_stall; k++) begin
      if (poke_start) begin
        start_valid = 1'b1;
        start_len   = 8'd7;
      end
      check({tag, "/hold_data"}, res_data, exp_data);
      check({tag, "/done_start_rdy"}, 64'(start_ready), 64'd0);
      check({tag, "/done_op_rdy"}, 64'(op_ready), 64'd0);
      step();
    end
    start_valid = 1'b0;
    check({tag, "/res_valid"}, 64'(res_valid), 64'd1);
    check({tag, "/data"}, res_data, exp_data);
    check({tag, "/ovf"}, 64'(res_ovf), 64'(exp_ovf));
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
    check({tag, "/idle_start_rdy"}, 64'(start_ready), 64'd1);
    check({tag, "/idle_busy"}, 64'(busy), 64'd0);
  endtask

  initial begin
    logic [64:0] s;
    bit          o;
    int          len;
    rst_n       = 1'b0;
    start_valid = 1'b0;
    start_len   = '0;
    op_valid    = 1'b0;
    op_a        = '0;
    op_b        = '0;
    res_ready   = 1'b0;
    #12;
    check("rst/start_rdy", 64'(start_ready), 64'd1);
    check("rst/busy", 64'(busy), 64'd0);
    check("rst/op_rdy", 64'(op_ready), 64'd0);
    check("rst/res_valid", 64'(res_valid), 64'd0);
    check("rst/res_data", res_data, 64'd0);
    check("rst/res_ovf", 64'(res_ovf), 64'd0);
    step();
    rst_n = 1'b1;
    step();

    va[0] = 32'd2; vb[0] = 32'd3;
    va[1] = 32'd4; vb[1] = 32'd5;
    va[2] = 32'd6; vb[2] = 32'd7;
    run_job("len3", 3, 0, 0, 1'b0, 64'd68, 1'b0);

    run_job("len0", 0, 0, 2, 1'b0, 64'd0, 1'b0);

    va[0] = 32'hFFFF_FFFF; vb[0] = 32'hFFFF_FFFF;
    va[1] = 32'hFFFF_FFFF; vb[1] = 32'hFFFF_FFFF;
    run_job("max2", 2, 0, 0, 1'b0, 64'hFFFF_FFFC_0000_0002, 1'b1);

    // 20000 + 12 + 0 + 0xFFFF*0x10001 (= 0xFFFFFFFF) = 4294987307
    va[0] = 32'd100;     vb[0] = 32'd200;
    va[1] = 32'd3;       vb[1] = 32'd4;
    va[2] = 32'd0;       vb[2] = 32'd9;
    va[3] = 32'h0000_FFFF; vb[3] = 32'h0001_0001;
    run_job("gaps4", 4, 3, 5, 1'b1, 64'd4294987307, 1'b0);

    // Reset after one of four pairs has been accumulated.
    va[0] = 32'd7; vb[0] = 32'd9;
    start_valid = 1'b1;
    start_len   = 8'd4;
    step();
    start_valid = 1'b0;
    op_valid = 1'b1;
    op_a     = va[0];
    op_b     = vb[0];
    step();
    op_valid = 1'b0;
    step();
    step();
    check("mid/busy", 64'(busy), 64'd1);
    check("mid/acc", res_data, 64'd63);
    rst_n = 1'b0;
    #1;
    check("mrst/start_rdy", 64'(start_ready), 64'd1);
    check("mrst/busy", 64'(busy), 64'd0);
    check("mrst/op_rdy", 64'(op_ready), 64'd0);
    check("mrst/res_valid", 64'(res_valid), 64'd0);
    check("mrst/res_data", res_data, 64'd0);
    check("mrst/res_ovf", 64'(res_ovf), 64'd0);
    step();
    step();
    rst_n = 1'b1;
    step();
    va[0] = 32'd10; vb[0] = 32'd10;
    run_job("post_rst", 1, 0, 0, 1'b0, 64'd100, 1'b0);

    for (int j = 0; j < 1000; j++) begin
      if (j == 0) len = 255;
      else if (j % 16 == 1) len = int'($urandom_range(0, 255));
      else len = int'($urandom_range(0, 31));
      s = '0;
      o = 1'b0;
      for (int i = 0; i < len; i++) begin
        va[i] = $urandom();
        vb[i] = $urandom();
        if (j % 5 == 0) va[i] = 32'hFFFF_FFFF - (va[i] & 32'hFF);
        s = {1'b0, s[63:0]} + {1'b0, 64'(va[i]) * 64'(vb[i])};
        o = o | s[64];
      end
      run_job("rnd", len, 1, int'($urandom_range(0, 3)), 1'b0, s[63:0], o);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
